nes_bus_glue: RTL and testbench

Host-side bus glue between the 2A03 `core` and its peripherals. Decodes CPU address bits [15:13] into one-hot 8 KiB region selects, generates gated read/write strobes per region, and steers the returned read data. Also carries the tick-gated delay line that re-times video sync signals. It sits in the top-level system alongside `core`, the video unit, work RAM and the cartridge mapper.

---
 rtl/nes_bus_glue_pkg.sv | 12 +
 rtl/onehot_decoder.sv | 14 +
 rtl/tick_delay_line.sv | 37 +++
 rtl/nes_bus_glue.sv | 83 ++++++++
 tb/tb_nes_bus_glue.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/nes_bus_glue_pkg.sv
// Shared constants for the NES host bus glue: region indices and default sizes.
package nes_bus_glue_pkg;

    localparam int unsigned REGION_MEM       = 0;
    localparam int unsigned REGION_PPU       = 1;
    localparam int unsigned REGION_CAR_FIRST = 2;

    localparam int unsigned DEF_SEL_WIDTH    = 3;
    localparam int unsigned DEF_DELAY_WIDTH  = 2;
    localparam int unsigned DEF_DELAY_LENGTH = 4;

endpackage

// File: rtl/onehot_decoder.sv
// Parameterised binary to one-hot decoder; exactly one output bit is set.
module onehot_decoder #(
    parameter int unsigned IN_WIDTH  = 3,
    parameter int unsigned OUT_WIDTH = 1 << IN_WIDTH
) (
    input  logic [IN_WIDTH-1:0]  bin_i,
    output logic [OUT_WIDTH-1:0] onehot_o
);

    for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_dec
        assign onehot_o[i] = (bin_i == IN_WIDTH'(i));
    end

endmodule

// File: rtl/tick_delay_line.sv
// Tick-enabled shift register with asynchronous clear; output is the last stage.
module tick_delay_line #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned LENGTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [LENGTH-1:0][WIDTH-1:0] stage_q;
    logic [LENGTH-1:0][WIDTH-1:0] stage_d;

    // Non-tick cycles hold every stage so only tick edges count as delay.
    always_comb begin
        stage_d = stage_q;
        if (tick_i) begin
            stage_d[0] = data_i;
            for (int n = 1; n < int'(LENGTH); n++) begin
                stage_d[n] = stage_q[n-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_o = stage_q[LENGTH-1];

endmodule

// File: rtl/nes_bus_glue.sv
// Host bus glue for the 2A03 core: region decode, gated strobes, read-data steering
// and the tick-gated video sync delay line.
module nes_bus_glue
    import nes_bus_glue_pkg::*;
#(
    parameter int unsigned P_sel_width    = DEF_SEL_WIDTH,
    parameter int unsigned P_delay_width  = DEF_DELAY_WIDTH,
    parameter int unsigned P_delay_length = DEF_DELAY_LENGTH
) (
    input  logic                         I_clock,
    input  logic                         I_reset,
    input  logic [15:0]                  I_addr,
    input  logic                         I_phy2,
    input  logic                         I_rdwr,
    output logic [(1<<P_sel_width)-1:0]  O_addr_dec,
    output logic                         O_mem_select,
    output logic                         O_ppu_select,
    output logic                         O_car_select,
    output logic                         O_mem_wren,
    output logic                         O_ppu_wren,
    output logic                         O_ppu_rden,
    output logic                         O_car_wren,
    input  logic [7:0]                   I_mem_data,
    input  logic [7:0]                   I_ppu_data,
    input  logic [7:0]                   I_car_data,
    output logic [7:0]                   O_rd_data,
    input  logic                         I_tick,
    input  logic [P_delay_width-1:0]     I_sync,
    output logic [P_delay_width-1:0]     O_sync
);

    localparam int unsigned REGION_COUNT = 1 << P_sel_width;

    logic [P_sel_width-1:0] region_idx;
    logic                   wren;
    logic                   rden;
    logic                   unused_addr_bits;

    assign region_idx       = I_addr[15 -: P_sel_width];
    assign unused_addr_bits = ^I_addr[15-P_sel_width:0];

    onehot_decoder #(
        .IN_WIDTH  (P_sel_width),
        .OUT_WIDTH (REGION_COUNT)
    ) u_decoder (
        .bin_i    (region_idx),
        .onehot_o (O_addr_dec)
    );

    assign O_mem_select = O_addr_dec[REGION_MEM];
    assign O_ppu_select = O_addr_dec[REGION_PPU];
    assign O_car_select = |O_addr_dec[REGION_COUNT-1:REGION_CAR_FIRST];

    // Strobes are purely combinational so they can only move with phy2/rdwr/addr.
    assign wren = I_phy2 & ~I_rdwr;
    assign rden = I_phy2 &  I_rdwr;

    assign O_mem_wren = wren & O_mem_select;
    assign O_ppu_wren = wren & O_ppu_select;
    assign O_ppu_rden = rden & O_ppu_select;
    assign O_car_wren = wren & O_car_select;

    always_comb begin
        O_rd_data = I_car_data;
        if (region_idx == P_sel_width'(REGION_MEM)) begin
            O_rd_data = I_mem_data;
        end else if (region_idx == P_sel_width'(REGION_PPU)) begin
            O_rd_data = I_ppu_data;
        end
    end

    tick_delay_line #(
        .WIDTH  (P_delay_width),
        .LENGTH (P_delay_length)
    ) u_sync_delay (
        .clk    (I_clock),
        .rst    (I_reset),
        .tick_i (I_tick),
        .data_i (I_sync),
        .data_o (O_sync)
    );

endmodule

// File: tb/tb_nes_bus_glue.sv
// Directed self-checking bench for nes_bus_glue with hand-computed expectations.
module tb_nes_bus_glue;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic        phy2;
    logic        rdwr;
    logic [7:0]  addr_dec;
    logic        mem_sel, ppu_sel, car_sel;
    logic        mem_wren, ppu_wren, ppu_rden, car_wren;
    logic [7:0]  mem_data, ppu_data, car_data, rd_data;
    logic        tick;
    logic [1:0]  sync_in, sync_out;

    int checks = 0;
    int errors = 0;

    nes_bus_glue dut (
        .I_clock      (clk),
        .I_reset      (rst),
        .I_addr       (addr),
        .I_phy2       (phy2),
        .I_rdwr       (rdwr),
        .O_addr_dec   (addr_dec),
        .O_mem_select (mem_sel),
        .O_ppu_select (ppu_sel),
        .O_car_select (car_sel),
        .O_mem_wren   (mem_wren),
        .O_ppu_wren   (ppu_wren),
        .O_ppu_rden   (ppu_rden),
        .O_car_wren   (car_wren),
        .I_mem_data   (mem_data),
        .I_ppu_data   (ppu_data),
        .I_car_data   (car_data),
        .O_rd_data    (rd_data),
        .I_tick       (tick),
        .I_sync       (sync_in),
        .O_sync       (sync_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs just after a falling edge, pass one rising edge, land on the next falling edge.
    task automatic step(input logic t, input logic [1:0] s);
        tick    = t;
        sync_in = s;
        @(negedge clk);
    endtask

    logic [15:0] sweep_addr [6] = '{16'h0000, 16'h2000, 16'h4000, 16'h6000, 16'h8000, 16'hE000};
    logic [7:0]  sweep_dec  [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h80};
    logic [2:0]  sweep_sel  [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};

    initial begin
        int ticks;
        logic [1:0] exp_sync;

        rst      = 1'b1;
        addr     = 16'h0000;
        phy2     = 1'b0;
        rdwr     = 1'b1;
        mem_data = 8'h11;
        ppu_data = 8'h22;
        car_data = 8'h33;
        tick     = 1'b1;
        sync_in  = 2'b11;
        #1;
        check("reset_sync", 16'(sync_out), 16'h0);
        @(negedge clk);
        @(negedge clk);
        check("reset_ticks_ignored", 16'(sync_out), 16'h0);

        // Region decode sweep
        for (int i = 0; i < 6; i++) begin
            addr = sweep_addr[i];
            #1;
            check($sformatf("dec_%h", sweep_addr[i]), 16'(addr_dec), 16'(sweep_dec[i]));
            check($sformatf("sel_%h", sweep_addr[i]), 16'({mem_sel, ppu_sel, car_sel}), 16'(sweep_sel[i]));
        end

        // Strobes: {mem_wren, ppu_wren, ppu_rden, car_wren}
        addr = 16'h2002; phy2 = 1'b1; rdwr = 1'b1; #1;
        check("ppu_read", 16'({mem_wren, ppu_wren, ppu_rden, car_wren}), 16'b0010);
        rdwr = 1'b0; #1;
        check("ppu_write", 16'({mem_wren, ppu_wren, ppu_rden, car_wren}), 16'b0100);
        phy2 = 1'b0; #1;
        check("ppu_idle", 16'({mem_wren, ppu_wren, ppu_rden, car_wren}), 16'b0000);
        addr = 16'h0123; phy2 = 1'b1; #1;
        check("mem_write", 16'({mem_wren, ppu_wren, ppu_rden, car_wren}), 16'b1000);
        addr = 16'h8000; #1;
        check("car_write", 16'({mem_wren, ppu_wren, ppu_rden, car_wren}), 16'b0001);
        rdwr = 1'b1; #1;
        check("car_read", 16'({mem_wren, ppu_wren, ppu_rden, car_wren}), 16'b0000);

        // Read data steering, independent of phy2/rdwr
        phy2 = 1'b0;
        addr = 16'h07FF; #1; check("rd_mem", 16'(rd_data), 16'h11);
        addr = 16'h2007; #1; check("rd_ppu", 16'(rd_data), 16'h22);
        addr = 16'hC000; #1; check("rd_car", 16'(rd_data), 16'h33);
        addr = 16'h1FFF; rdwr = 1'b0; #1; check("rd_mem_top", 16'(rd_data), 16'h11);
        addr = 16'h4000; #1; check("rd_car_low", 16'(rd_data), 16'h33);

        // Release reset, then one-shot pulse with a tick every 4th cycle
        tick = 1'b0; sync_in = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ticks = 0;
        for (int c = 0; c < 24; c++) begin
            step(c % 4 == 0, (c == 0) ? 2'b11 : 2'b00);
            if (c % 4 == 0) ticks++;
            exp_sync = (ticks == 4) ? 2'b11 : 2'b00;
            check($sformatf("delay_c%0d", c), 16'(sync_out), 16'(exp_sync));
        end

        // Fill with 10, then hold tick low while sync toggles
        for (int c = 0; c < 4; c++) step(1'b1, 2'b10);
        check("fill_10", 16'(sync_out), 16'h2);
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 2'(c));
            if (c % 10 == 9) check($sformatf("hold_c%0d", c), 16'(sync_out), 16'h2);
        end

        // Fill with 11, then asynchronous reset between edges
        for (int c = 0; c < 4; c++) step(1'b1, 2'b11);
        check("fill_11", 16'(sync_out), 16'h3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", 16'(sync_out), 16'h0);
        @(negedge clk);
        step(1'b1, 2'b11);
        check("reset_hold", 16'(sync_out), 16'h0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 2'b00);
            check($sformatf("refill_t%0d", c), 16'(sync_out), 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
